// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned NUM_REGS   = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH  = 2;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;

    // Saturation point of a per-register outstanding-write counter.
    localparam cnt_t CNT_MAX = '1;

    // Grant encoding; also the bit position of each requester in req/gnt vectors.
    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the two write-back requesters, the register-file write port and the
// pending-write scoreboard signals.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                a_valid;
    addr_t               a_addr;
    data_t               a_data;
    logic                a_ready;

    logic                b_valid;
    addr_t               b_addr;
    data_t               b_data;
    logic                b_ready;

    logic                rf_write;
    addr_t               rf_inaddress;
    data_t               rf_in;

    logic                pend_set;
    addr_t               pend_addr;
    logic                pend_ready;
    logic [NUM_REGS-1:0] pending;

    // Arbiter side.
    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  pend_set, pend_addr,
        output a_ready, b_ready,
        output rf_write, rf_inaddress, rf_in,
        output pend_ready, pending
    );

    // Requester / decode / register-file side.
    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output pend_set, pend_addr,
        input  a_ready, b_ready,
        input  rf_write, rf_inaddress, rf_in,
        input  pend_ready, pending
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter (rr_arbiter2). gnt is combinational from req and
// the last-grant flop; bit GNT_A is requester A, bit GNT_B is requester B.
module regfile_wb_arbiter_rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    gnt_e last_grant;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == GNT_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Requesters hold req until granted, so every grant is a transfer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_grant <= GNT_B;
        end else if (gnt[1]) begin
            last_grant <= GNT_B;
        end else if (gnt[0]) begin
            last_grant <= GNT_A;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU (A) and load (B)
// write-back paths, and tracks outstanding writes per register for RAW stalls.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input logic                  CLK,
    input logic                  RESET,
    regfile_wb_arbiter_if.slave  bus
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       xfer;
    wb_req_t    sel;

    logic       rf_write_q;
    addr_t      rf_addr_q;
    data_t      rf_data_q;

    cnt_t       cnt_q [NUM_REGS];
    cnt_t       cnt_d [NUM_REGS];
    logic       pend_inc;
    logic [NUM_REGS-1:0] inc_hit;
    logic [NUM_REGS-1:0] dec_hit;

    assign req = {bus.b_valid, bus.a_valid};

    regfile_wb_arbiter_rr_arbiter2 u_arb (
        .CLK   (CLK),
        .RESET (RESET),
        .req   (req),
        .gnt   (gnt)
    );

    // Readies are the grants, forced low while in reset.
    always_comb begin
        bus.a_ready = gnt[0] & ~RESET;
        bus.b_ready = gnt[1] & ~RESET;
        xfer        = bus.a_ready | bus.b_ready;
        sel         = bus.b_ready ? '{addr: bus.b_addr, data: bus.a_data & '0 | bus.b_data}
                                  : '{addr: bus.a_addr, data: bus.a_data};
    end

    // Capture the accepted write; it drives the register file for one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            rf_write_q <= xfer;
            if (xfer) begin
                rf_addr_q <= sel.addr;
                rf_data_q <= sel.data;
            end
        end
    end

    assign bus.rf_write     = rf_write_q;
    assign bus.rf_inaddress = rf_addr_q;
    assign bus.rf_in        = rf_data_q;

    // Decode may only mark a new pending write when that register's counter has room.
    always_comb begin
        bus.pend_ready = (cnt_q[bus.pend_addr] != CNT_MAX);
        pend_inc       = bus.pend_set & bus.pend_ready;
    end

    // Per-register increment/decrement strobes and PENDING flags.
    always_comb begin
        inc_hit     = '0;
        dec_hit     = '0;
        bus.pending = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            inc_hit[i]     = pend_inc && (bus.pend_addr == addr_t'(i));
            dec_hit[i]     = xfer && (sel.addr == addr_t'(i));
            bus.pending[i] = (cnt_q[i] != '0);
        end
    end

    // Counter next state: simultaneous set and retire cancel; never wraps below zero.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_hit[i] && !dec_hit[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_hit[i] && !inc_hit[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Counter array state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Stimulus pushes expected register-file
// writes into a queue; a negedge monitor pops and compares each RF_WRITE cycle.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    int      tests = 0;
    int      fails = 0;
    wb_req_t exp_q[$];
    wb_req_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Move to just after the next active edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present an A write that is expected to be granted immediately.
    task automatic a_write(input addr_t ad, input data_t d);
        bus.a_valid = 1'b1;
        bus.a_addr  = ad;
        bus.a_data  = d;
        exp_q.push_back('{addr: ad, data: d});
        @(negedge CLK);
        check("a_write_ready", bus.a_ready, 1);
        tick();
        bus.a_valid = 1'b0;
    endtask

    // Scoreboard monitor: every register-file write must match the next expected one.
    always @(negedge CLK) begin
        if (bus.rf_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bus.rf_inaddress, bus.rf_in);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_addr", bus.rf_inaddress, mon_e.addr);
                check("wb_data", bus.rf_in, mon_e.data);
            end
        end
    end

    initial begin
        bus.a_valid   = 1'b1;
        bus.a_addr    = 3'd1;
        bus.a_data    = 8'h11;
        bus.b_valid   = 1'b1;
        bus.b_addr    = 3'd2;
        bus.b_data    = 8'h22;
        bus.pend_set  = 1'b0;
        bus.pend_addr = 3'd0;
        RESET         = 1'b1;

        // 1. Reset: readies low even with both requesters valid.
        tick();
        @(negedge CLK);
        check("reset_a_ready", bus.a_ready, 0);
        check("reset_b_ready", bus.b_ready, 0);
        tick();
        RESET       = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge CLK);
        check("reset_rf_write", bus.rf_write, 0);
        check("reset_rf_addr", bus.rf_inaddress, 0);
        check("reset_rf_in", bus.rf_in, 0);
        check("reset_pending", bus.pending, 8'h00);
        check("reset_pend_ready", bus.pend_ready, 1);
        tick();

        // 2. Single A write.
        bus.a_valid = 1'b1;
        bus.a_addr  = 3'd3;
        bus.a_data  = 8'h2A;
        exp_q.push_back('{addr: 3'd3, data: 8'h2A});
        @(negedge CLK);
        check("t2_a_ready", bus.a_ready, 1);
        check("t2_b_ready", bus.b_ready, 0);
        tick();
        bus.a_valid = 1'b0;
        @(negedge CLK);
        check("t2_rf_write", bus.rf_write, 1);
        tick();

        // 3. Reset, then both valid for 4 cycles: A,B,A,B back to back.
        RESET = 1'b1;
        tick();
        RESET       = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_addr  = 3'd1;
        bus.a_data  = 8'h11;
        bus.b_valid = 1'b1;
        bus.b_addr  = 3'd2;
        bus.b_data  = 8'h22;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k % 2 == 0) ? '{addr: 3'd1, data: 8'h11}
                                         : '{addr: 3'd2, data: 8'h22});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("t3_a_ready", bus.a_ready, (k % 2 == 0) ? 1 : 0);
            check("t3_b_ready", bus.b_ready, (k % 2 == 0) ? 0 : 1);
            check("t3_rf_write", bus.rf_write, (k != 0) ? 1 : 0);
            tick();
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge CLK);
        check("t3_rf_write_last", bus.rf_write, 1);
        tick();

        // 4. Scoreboard on register 5: saturate, retire, set+retire, drain, retire at zero.
        bus.pend_addr = 3'd5;
        for (int k = 0; k < 3; k++) begin
            bus.pend_set = 1'b1;
            @(negedge CLK);
            check("t4_pend_ready_fill", bus.pend_ready, 1);
            tick();
        end
        bus.pend_set = 1'b0;
        @(negedge CLK);
        check("t4_pending_full", bus.pending, 8'h20);
        check("t4_pend_ready_full", bus.pend_ready, 0);
        tick();
        bus.pend_set = 1'b1;
        tick();
        bus.pend_set  = 1'b0;
        bus.pend_addr = 3'd6;
        @(negedge CLK);
        check("t4_pend_ready_other", bus.pend_ready, 1);
        check("t4_pending_ignored", bus.pending, 8'h20);
        tick();
        bus.pend_addr = 3'd5;
        a_write(3'd5, 8'h55);
        @(negedge CLK);
        check("t4_pend_ready_after_dec", bus.pend_ready, 1);
        check("t4_pending_after_dec", bus.pending, 8'h20);
        tick();
        bus.pend_set = 1'b1;
        a_write(3'd5, 8'h66);
        bus.pend_set = 1'b0;
        @(negedge CLK);
        check("t4_set_and_dec_ready", bus.pend_ready, 1);
        check("t4_set_and_dec_pending", bus.pending, 8'h20);
        tick();
        a_write(3'd5, 8'h77);
        @(negedge CLK);
        check("t4_pending_cnt1", bus.pending, 8'h20);
        tick();
        a_write(3'd5, 8'h88);
        @(negedge CLK);
        check("t4_pending_cnt0", bus.pending, 8'h00);
        tick();
        a_write(3'd5, 8'h99);
        @(negedge CLK);
        check("t4_pending_hold0", bus.pending, 8'h00);
        check("t4_pend_ready_hold0", bus.pend_ready, 1);
        tick();

        // 5. B write accepted, RESET on the next edge drops it and clears pending.
        bus.pend_set  = 1'b1;
        bus.pend_addr = 3'd2;
        tick();
        bus.pend_set = 1'b0;
        @(negedge CLK);
        check("t5_pending_set", bus.pending, 8'h04);
        tick();
        bus.b_valid = 1'b1;
        bus.b_addr  = 3'd7;
        bus.b_data  = 8'h77;
        exp_q.push_back('{addr: 3'd7, data: 8'h77});
        @(negedge CLK);
        check("t5_b_ready", bus.b_ready, 1);
        tick();
        bus.b_valid = 1'b0;
        RESET       = 1'b1;
        @(negedge CLK);
        check("t5_rf_write_captured", bus.rf_write, 1);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check("t5_rf_write_dropped", bus.rf_write, 0);
        check("t5_pending_clear", bus.pending, 8'h00);
        tick();

        // 6. Same address on both; A wins the first tie after reset, B's data lands last.
        bus.a_valid = 1'b1;
        bus.a_addr  = 3'd4;
        bus.a_data  = 8'hAA;
        bus.b_valid = 1'b1;
        bus.b_addr  = 3'd4;
        bus.b_data  = 8'hBB;
        exp_q.push_back('{addr: 3'd4, data: 8'hAA});
        exp_q.push_back('{addr: 3'd4, data: 8'hBB});
        @(negedge CLK);
        check("t6_a_first", bus.a_ready, 1);
        check("t6_b_waits", bus.b_ready, 0);
        tick();
        bus.a_valid = 1'b0;
        @(negedge CLK);
        check("t6_b_second", bus.b_ready, 1);
        check("t6_a_idle", bus.a_ready, 0);
        tick();
        bus.b_valid = 1'b0;
        @(negedge CLK);
        check("t6_rf_write_second", bus.rf_write, 1);
        tick();
        @(negedge CLK);
        check("t6_rf_write_idle", bus.rf_write, 0);
        tick();

        check("expected_writes_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
